// File: rtl/pipeline_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller:
// operand-forward selects, sequencing FSM states and the forwarding pick rule.
package pipeline_pkg;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int CNT_W_DEF        = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Newest producer wins: Exec result beats the older Mem-stage write.
  function automatic fwd_sel_e fwd_pick(input logic [4:0] src,
                                        input logic       used,
                                        input logic [4:0] rd_exec,
                                        input logic       wr_en_exec,
                                        input logic [4:0] rd_mem,
                                        input logic       wr_en_mem);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (used && (src != 5'd0)) begin
      if (wr_en_exec && (src == rd_exec)) begin
        sel = FWD_MEM;
      end else if (wr_en_mem && (src == rd_mem)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, operand forwarding
// selects, halt drain sequencing and stall/flush event counters.
//
// state     | meaning
// ST_RUN    | normal issue; stalls on load-use, flushes on taken branch
// ST_DRAIN  | halt seen in IF; fetch frozen while older instructions retire
// ST_HALTED | pipeline empty and stopped until reset
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rs1_dec,
  input  logic [4:0]       rs2_dec,
  input  logic             rs1_used_dec,
  input  logic             rs2_used_dec,
  input  logic [4:0]       rd_exec,
  input  logic             wr_en_exec,
  input  logic             load_exec,
  input  logic [4:0]       rd_mem,
  input  logic             wr_en_mem,
  input  logic             branch_taken_mem,
  input  logic             halt_if,
  output logic             stall_if,
  output logic             stall_dec,
  output logic             bubble_exec,
  output logic             flush_dec,
  output logic             flush_exec,
  output logic             flush_mem,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  fwd_sel_e           fwd_a_q, fwd_a_d;
  fwd_sel_e           fwd_b_q, fwd_b_d;
  logic               load_use;
  logic               stall_ev;
  logic               flush_ev;

  assign load_use = load_exec && wr_en_exec && (rd_exec != 5'd0) &&
                    ((rs1_used_dec && (rs1_dec == rd_exec)) ||
                     (rs2_used_dec && (rs2_dec == rd_exec)));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_if    = 1'b0;
    stall_dec   = 1'b0;
    bubble_exec = 1'b0;
    flush_dec   = 1'b0;
    flush_exec  = 1'b0;
    flush_mem   = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    fwd_a_d     = fwd_pick(rs1_dec, rs1_used_dec, rd_exec, wr_en_exec, rd_mem, wr_en_mem);
    fwd_b_d     = fwd_pick(rs2_dec, rs2_used_dec, rd_exec, wr_en_exec, rd_mem, wr_en_mem);
    case (state_q)
      ST_RUN: begin
        if (branch_taken_mem) begin
          flush_dec  = 1'b1;
          flush_exec = 1'b1;
          flush_mem  = 1'b1;
          flush_ev   = 1'b1;
          fwd_a_d    = FWD_RF;
          fwd_b_d    = FWD_RF;
        end else if (load_use) begin
          stall_if    = 1'b1;
          stall_dec   = 1'b1;
          bubble_exec = 1'b1;
          stall_ev    = 1'b1;
          fwd_a_d     = FWD_RF;
          fwd_b_d     = FWD_RF;
        end else if (halt_if) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // A redirect means the halt was fetched down the wrong path.
        if (branch_taken_mem) begin
          flush_dec  = 1'b1;
          flush_exec = 1'b1;
          flush_mem  = 1'b1;
          flush_ev   = 1'b1;
          fwd_a_d    = FWD_RF;
          fwd_b_d    = FWD_RF;
          state_d    = ST_RUN;
          drain_d    = '0;
        end else begin
          stall_if  = 1'b1;
          flush_dec = 1'b1;
          if (drain_q == '0) begin
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      ST_HALTED: begin
        stall_if  = 1'b1;
        flush_dec = 1'b1;
        fwd_a_d   = FWD_RF;
        fwd_b_d   = FWD_RF;
      end
      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign halt      = (state_q == ST_HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (1'b0),
    .inc_i (stall_ev),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (1'b0),
    .inc_i (flush_ev),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus hand-written
// drain, abort, reset and counter-saturation sequences.
module tb_hazard_ctrl;

  typedef struct {
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rde; logic we; logic ld;
    logic [4:0] rdm; logic wm;
    logic       br;
    logic       e_stall; logic e_flush;
    logic       chk_fwd; logic [1:0] e_fa; logic [1:0] e_fb;
  } vec_t;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  rs1_dec, rs2_dec, rd_exec, rd_mem;
  logic        rs1_used_dec, rs2_used_dec, wr_en_exec, load_exec, wr_en_mem;
  logic        branch_taken_mem, halt_if;
  logic        stall_if, stall_dec, bubble_exec, flush_dec, flush_exec, flush_mem, halt;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;
  int exp_sc = 0;
  int exp_fc = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec),
    .rs1_used_dec(rs1_used_dec), .rs2_used_dec(rs2_used_dec),
    .rd_exec(rd_exec), .wr_en_exec(wr_en_exec), .load_exec(load_exec),
    .rd_mem(rd_mem), .wr_en_mem(wr_en_mem),
    .branch_taken_mem(branch_taken_mem), .halt_if(halt_if),
    .stall_if(stall_if), .stall_dec(stall_dec), .bubble_exec(bubble_exec),
    .flush_dec(flush_dec), .flush_exec(flush_exec), .flush_mem(flush_mem),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic vec_t mk(input int rs1, input int u1, input int rs2, input int u2,
                              input int rde, input int we, input int ld,
                              input int rdm, input int wm, input int br,
                              input int es, input int ef, input int cf,
                              input int fa, input int fb);
    vec_t v;
    v.rs1 = 5'(rs1); v.u1 = 1'(u1); v.rs2 = 5'(rs2); v.u2 = 1'(u2);
    v.rde = 5'(rde); v.we = 1'(we); v.ld = 1'(ld);
    v.rdm = 5'(rdm); v.wm = 1'(wm); v.br = 1'(br);
    v.e_stall = 1'(es); v.e_flush = 1'(ef); v.chk_fwd = 1'(cf);
    v.e_fa = 2'(fa); v.e_fb = 2'(fb);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic apply(input vec_t v);
    rs1_dec = v.rs1; rs1_used_dec = v.u1; rs2_dec = v.rs2; rs2_used_dec = v.u2;
    rd_exec = v.rde; wr_en_exec = v.we; load_exec = v.ld;
    rd_mem = v.rdm; wr_en_mem = v.wm; branch_taken_mem = v.br;
    halt_if = 1'b0;
  endtask

  task automatic clear_in();
    apply(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0));
  endtask

  task automatic load_use_in();
    apply(mk(5,1,0,0, 5,1,1, 0,0,0, 0,0,0,0,0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    clear_in();
    #2 rstn = 1'b1;
  endtask

  initial begin
    // rs1 u1 rs2 u2 | rde we ld | rdm wm | br | stall flush chkfwd fa fb
    vecs[0]  = mk( 0,0, 0,0,  0,0,0,  0,0, 0, 0,0,1, 0,0);
    vecs[1]  = mk( 5,1, 0,0,  5,1,1,  0,0, 0, 1,0,1, 0,0);
    vecs[2]  = mk( 5,1, 0,0,  0,0,0,  5,1, 0, 0,0,1, 2,0);
    vecs[3]  = mk( 7,1, 3,1,  3,1,0,  0,0, 0, 0,0,1, 0,1);
    vecs[4]  = mk( 3,1, 3,1,  3,1,0,  3,1, 0, 0,0,1, 1,1);
    vecs[5]  = mk( 0,1, 0,0,  0,1,1,  0,1, 0, 0,0,1, 0,0);
    vecs[6]  = mk( 9,0, 9,0,  9,1,1,  9,1, 0, 0,0,1, 0,0);
    vecs[7]  = mk( 4,1,12,1, 12,1,1,  4,1, 0, 1,0,1, 0,0);
    vecs[8]  = mk( 6,1, 0,0,  6,0,1,  6,1, 0, 0,0,1, 2,0);
    vecs[9]  = mk( 5,1, 0,0,  5,1,1,  0,0, 1, 0,1,0, 0,0);
    vecs[10] = mk( 8,1, 0,0,  0,0,0,  8,0, 0, 0,0,1, 0,0);
    vecs[11] = mk( 1,1, 2,1,  1,1,0,  2,1, 0, 0,0,1, 1,2);

    clear_in();
    #12;
    chk("rst_halt", halt, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_flush_dec", flush_dec, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    #1 rstn = 1'b1;

    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d_stall_if", i), stall_if, vecs[i].e_stall);
      chk($sformatf("v%0d_stall_dec", i), stall_dec, vecs[i].e_stall);
      chk($sformatf("v%0d_bubble", i), bubble_exec, vecs[i].e_stall);
      chk($sformatf("v%0d_flush_dec", i), flush_dec, vecs[i].e_flush);
      chk($sformatf("v%0d_flush_exec", i), flush_exec, vecs[i].e_flush);
      chk($sformatf("v%0d_flush_mem", i), flush_mem, vecs[i].e_flush);
      exp_sc += int'(vecs[i].e_stall);
      exp_fc += int'(vecs[i].e_flush);
      @(posedge clk); #1;
      if (vecs[i].chk_fwd) begin
        chk($sformatf("v%0d_fwd_a", i), fwd_a_sel, vecs[i].e_fa);
        chk($sformatf("v%0d_fwd_b", i), fwd_b_sel, vecs[i].e_fb);
      end
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, exp_sc);
      chk($sformatf("v%0d_flush_cnt", i), flush_cnt, exp_fc);
    end
    clear_in();

    // Full drain into HALTED, then inputs ignored.
    do_reset();
    @(posedge clk); #1;
    halt_if = 1'b1;
    #1 chk("halt_req_no_stall", stall_if, 0);
    @(posedge clk); #1;
    halt_if = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      #1;
      chk($sformatf("drain%0d_stall_if", d), stall_if, 1);
      chk($sformatf("drain%0d_flush_dec", d), flush_dec, 1);
      chk($sformatf("drain%0d_flush_exec", d), flush_exec, 0);
      chk($sformatf("drain%0d_halt", d), halt, 0);
      @(posedge clk); #1;
    end
    chk("halted_halt", halt, 1);
    chk("halted_stall_if", stall_if, 1);
    chk("halted_flush_dec", flush_dec, 1);
    apply(mk(5,1,0,0, 5,1,1, 0,0,1, 0,0,0,0,0));
    halt_if = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("halted%0d_halt", k), halt, 1);
      chk($sformatf("halted%0d_flush_mem", k), flush_mem, 0);
      chk($sformatf("halted%0d_stall_dec", k), stall_dec, 0);
      @(posedge clk); #1;
    end
    chk("halted_stall_cnt", stall_cnt, 0);
    chk("halted_flush_cnt", flush_cnt, 0);
    clear_in();

    // Redirect at drain cycle 2 discards the halt.
    do_reset();
    @(posedge clk); #1;
    halt_if = 1'b1;
    @(posedge clk); #1;
    halt_if = 1'b0;
    #1 chk("abort_d1_stall_if", stall_if, 1);
    @(posedge clk); #1;
    branch_taken_mem = 1'b1;
    #1;
    chk("abort_flush_dec", flush_dec, 1);
    chk("abort_flush_exec", flush_exec, 1);
    chk("abort_flush_mem", flush_mem, 1);
    chk("abort_stall_if", stall_if, 0);
    @(posedge clk); #1;
    branch_taken_mem = 1'b0;
    #1;
    chk("abort_run_stall_if", stall_if, 0);
    chk("abort_run_flush_dec", flush_dec, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_halt", halt, 0);
    chk("abort_flush_cnt", flush_cnt, 1);

    // Asynchronous reset in the middle of a drain.
    @(posedge clk); #1;
    halt_if = 1'b1;
    @(posedge clk); #1;
    halt_if = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_stall_if", stall_if, 0);
    chk("mid_rst_flush_dec", flush_dec, 0);
    chk("mid_rst_flush_cnt", flush_cnt, 0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall_if", stall_if, 0);
    chk("post_rst_flush_dec", flush_dec, 0);
    chk("post_rst_halt", halt, 0);

    // Stall counter saturation, then async reset out of HALTED.
    do_reset();
    @(posedge clk); #1;
    load_use_in();
    repeat (65535) @(posedge clk);
    #1 chk("sat_reach", stall_cnt, 65535);
    @(posedge clk); #1;
    chk("sat_hold", stall_cnt, 65535);
    chk("sat_stall_if", stall_if, 1);
    clear_in();
    halt_if = 1'b1;
    @(posedge clk); #1;
    halt_if = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_halted", halt, 1);
    chk("sat_halted_cnt", stall_cnt, 65535);
    rstn = 1'b0;
    #1;
    chk("halt_rst_halt", halt, 0);
    chk("halt_rst_stall_cnt", stall_cnt, 0);
    chk("halt_rst_flush_cnt", flush_cnt, 0);
    chk("halt_rst_stall_if", stall_if, 0);
    #1 rstn = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
